// File: rtl/timing_err_mon.sv
// Timing-error monitor: counts origin/leading capture mismatches against a late shadow
// capture over fixed windows of valid samples and thresholds them into error levels.
//
// state    | meaning
// S_IDLE   | monitor disabled, counters held at 0
// S_SETTLE | blanking after enable or a clk_sel change
// S_COUNT  | accumulating mismatches over WIN valid samples
// S_REPORT | single cycle publishing flags and snapshots
module timing_err_mon #(
  parameter int W      = 8,
  parameter int WIN    = 16,
  parameter int THRESH = 2,
  parameter int SETTLE = 4,
  localparam int CNT_W = $clog2(WIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid,
  input  logic [W-1:0]     data_origin,
  input  logic [W-1:0]     data_leading,
  input  logic [W-1:0]     data_shadow,
  input  logic             clk_sel,
  output logic             error_origin,
  output logic             error_leading,
  output logic [CNT_W-1:0] cnt_origin,
  output logic [CNT_W-1:0] cnt_leading,
  output logic             win_done
);

  localparam int SET_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_REPORT
  } state_t;

  state_t           state;
  logic [SET_W-1:0] settle_cnt;
  logic [CNT_W-1:0] samp_cnt;
  logic [CNT_W-1:0] cnt_o;
  logic [CNT_W-1:0] cnt_l;
  logic             clk_sel_q;
  logic             mis_o;
  logic             mis_l;
  logic             chg;

  assign mis_o = (data_origin != data_shadow);
  assign mis_l = (data_leading != data_shadow);
  assign chg   = (clk_sel != clk_sel_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      settle_cnt    <= '0;
      samp_cnt      <= '0;
      cnt_o         <= '0;
      cnt_l         <= '0;
      clk_sel_q     <= 1'b0;
      error_origin  <= 1'b0;
      error_leading <= 1'b0;
      cnt_origin    <= '0;
      cnt_leading   <= '0;
      win_done      <= 1'b0;
    end else begin
      clk_sel_q <= clk_sel;
      win_done  <= 1'b0;
      if (!en) begin
        // Disabling clears the levels so the phase controller freezes.
        state         <= S_IDLE;
        settle_cnt    <= '0;
        samp_cnt      <= '0;
        cnt_o         <= '0;
        cnt_l         <= '0;
        error_origin  <= 1'b0;
        error_leading <= 1'b0;
        cnt_origin    <= '0;
        cnt_leading   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
            samp_cnt   <= '0;
            cnt_o      <= '0;
            cnt_l      <= '0;
          end
          S_SETTLE: begin
            if (chg) begin
              settle_cnt <= '0;
            end else if (settle_cnt == SET_W'(SETTLE - 1)) begin
              state      <= S_COUNT;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          S_COUNT: begin
            if (chg) begin
              // Phase switched mid-window: drop the partial window, keep flags.
              state      <= S_SETTLE;
              settle_cnt <= '0;
              samp_cnt   <= '0;
              cnt_o      <= '0;
              cnt_l      <= '0;
            end else if (valid) begin
              if (samp_cnt < CNT_W'(WIN)) samp_cnt <= samp_cnt + 1'b1;
              if (mis_o && (cnt_o < CNT_W'(WIN))) cnt_o <= cnt_o + 1'b1;
              if (mis_l && (cnt_l < CNT_W'(WIN))) cnt_l <= cnt_l + 1'b1;
              if (samp_cnt == CNT_W'(WIN - 1)) state <= S_REPORT;
            end
          end
          S_REPORT: begin
            error_origin  <= (cnt_o >= CNT_W'(THRESH));
            error_leading <= (cnt_l >= CNT_W'(THRESH));
            cnt_origin    <= cnt_o;
            cnt_leading   <= cnt_l;
            win_done      <= 1'b1;
            samp_cnt      <= '0;
            cnt_o         <= '0;
            cnt_l         <= '0;
            settle_cnt    <= '0;
            state         <= chg ? S_SETTLE : S_COUNT;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timing_err_mon.sv
// Bench for timing_err_mon: randomized data against a cycle-level behavioural model,
// plus directed window scenarios.
module tb_timing_err_mon;
  localparam int W      = 8;
  localparam int WIN    = 16;
  localparam int THRESH = 2;
  localparam int SETTLE = 4;
  localparam int CNT_W  = $clog2(WIN + 1);
  localparam int VW     = 2 * CNT_W + 3;

  logic             clk = 1'b0;
  logic             rst, en, valid, clk_sel;
  logic [W-1:0]     d_o, d_l, d_s;
  logic             error_origin, error_leading, win_done;
  logic [CNT_W-1:0] cnt_origin, cnt_leading;

  timing_err_mon #(.W(W), .WIN(WIN), .THRESH(THRESH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .en(en), .valid(valid),
    .data_origin(d_o), .data_leading(d_l), .data_shadow(d_s),
    .clk_sel(clk_sel),
    .error_origin(error_origin), .error_leading(error_leading),
    .cnt_origin(cnt_origin), .cnt_leading(cnt_leading),
    .win_done(win_done)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    trace_err = 0;
  string first_bad = "";
  int    dut_dones = 0;

  // Behavioural model: enabled flag, blanking cycles left, window tallies.
  bit m_active, m_rpt, m_sel;
  int m_blank, m_nv, m_no, m_nl, m_dones;
  bit e_eo, e_el, e_done;
  int e_co, e_cl;

  task automatic model_step();
    bit chg;
    e_done = 1'b0;
    if (rst) begin
      m_active = 0; m_rpt = 0; m_sel = 0; m_blank = 0;
      m_nv = 0; m_no = 0; m_nl = 0;
      e_eo = 0; e_el = 0; e_co = 0; e_cl = 0;
      return;
    end
    chg   = (clk_sel != m_sel);
    m_sel = clk_sel;
    if (!en) begin
      m_active = 0; m_rpt = 0; m_nv = 0; m_no = 0; m_nl = 0;
      e_eo = 0; e_el = 0; e_co = 0; e_cl = 0;
    end else if (!m_active) begin
      m_active = 1; m_blank = SETTLE; m_nv = 0; m_no = 0; m_nl = 0;
    end else if (m_rpt) begin
      e_eo = (m_no >= THRESH); e_el = (m_nl >= THRESH);
      e_co = m_no; e_cl = m_nl; e_done = 1; m_dones++;
      m_rpt = 0; m_nv = 0; m_no = 0; m_nl = 0;
      if (chg) m_blank = SETTLE;
    end else if (chg) begin
      m_blank = SETTLE; m_nv = 0; m_no = 0; m_nl = 0;
    end else if (m_blank > 0) begin
      m_blank--;
    end else if (valid) begin
      m_nv++;
      if (d_o != d_s) m_no++;
      if (d_l != d_s) m_nl++;
      if (m_nv == WIN) m_rpt = 1;
    end
  endtask

  function automatic logic [VW-1:0] act_vec();
    return {error_origin, error_leading, cnt_origin, cnt_leading, win_done};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_eo, e_el, CNT_W'(e_co), CNT_W'(e_cl), e_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (win_done === 1'b1) dut_dones++;
    if (act_vec() !== exp_vec()) begin
      if (trace_err == 0)
        first_bad = $sformatf("t=%0t got %h want %h", $time, act_vec(), exp_vec());
      trace_err++;
    end
  endtask

  task automatic drive(input bit v, input bit mo, input bit ml);
    logic [W-1:0] x;
    valid = v;
    d_s = W'($urandom);
    x = W'($urandom); if (x == '0) x = 1;
    d_o = mo ? (d_s ^ x) : d_s;
    x = W'($urandom); if (x == '0) x = 1;
    d_l = ml ? (d_s ^ x) : d_s;
  endtask

  function automatic logic [WIN-1:0] rand_mask(int k);
    logic [WIN-1:0] m = '0;
    while ($countones(m) < k) m[$urandom_range(0, WIN-1)] = 1'b1;
    return m;
  endfunction

  task automatic restart();
    en = 1'b0; drive(1, 0, 0); tick();
    en = 1'b1;
    repeat (SETTLE + 1) begin drive(1, 1, 1); tick(); end
  endtask

  task automatic run_window(input logic [WIN-1:0] mo, input logic [WIN-1:0] ml);
    for (int i = 0; i < WIN; i++) begin drive(1, mo[i], ml[i]); tick(); end
    drive($urandom_range(0, 1), 1, 1);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clk_sel = 1'b0; drive(0, 0, 0);
    tick(); tick();
    n_cmp++;
    if (act_vec() !== '0) begin
      n_bad++; $display("FAIL reset_outputs got %h want 0", act_vec());
    end
    n_cmp++;
    if (trace_err !== 0) begin
      n_bad++; $display("FAIL reset_trace %0d cycles differ, first %s", trace_err, first_bad);
    end
    trace_err = 0;
    rst = 1'b0;
  endtask

  task automatic test_clean();
    int first = -1;
    logic [2*CNT_W+1:0] at_done = '1;
    en = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      drive(1, 0, 0); tick();
      if (win_done === 1'b1 && first < 0) begin
        first = i; at_done = {error_origin, error_leading, cnt_origin, cnt_leading};
      end
    end
    n_cmp++;
    if (first !== 22) begin
      n_bad++; $display("FAIL clean_latency got %0d want 22", first);
    end
    n_cmp++;
    if (at_done !== '0) begin
      n_bad++; $display("FAIL clean_flags got %h want 0", at_done);
    end
    n_cmp++;
    if (trace_err !== 0) begin
      n_bad++; $display("FAIL clean_trace %0d cycles differ, first %s", trace_err, first_bad);
    end
    trace_err = 0;
  endtask

  task automatic test_origin_errs();
    restart();
    run_window(rand_mask(3), '0);
    n_cmp++;
    if ({win_done, error_origin, error_leading, cnt_origin, cnt_leading} !==
        {1'b1, 1'b1, 1'b0, CNT_W'(3), CNT_W'(0)}) begin
      n_bad++;
      $display("FAIL origin3 got done=%b eo=%b el=%b co=%0d cl=%0d want 1 1 0 3 0",
               win_done, error_origin, error_leading, cnt_origin, cnt_leading);
    end
    n_cmp++;
    if (trace_err !== 0) begin
      n_bad++; $display("FAIL origin3_trace %0d cycles differ, first %s", trace_err, first_bad);
    end
    trace_err = 0;
  endtask

  task automatic test_threshold();
    restart();
    run_window(rand_mask(1), '0);
    n_cmp++;
    if ({win_done, error_origin, cnt_origin} !== {1'b1, 1'b0, CNT_W'(1)}) begin
      n_bad++; $display("FAIL thresh_below got done=%b eo=%b co=%0d want 1 0 1",
                        win_done, error_origin, cnt_origin);
    end
    run_window(rand_mask(THRESH), '0);
    n_cmp++;
    if ({win_done, error_origin, cnt_origin} !== {1'b1, 1'b1, CNT_W'(THRESH)}) begin
      n_bad++; $display("FAIL thresh_at got done=%b eo=%b co=%0d want 1 1 %0d",
                        win_done, error_origin, cnt_origin, THRESH);
    end
    n_cmp++;
    if (trace_err !== 0) begin
      n_bad++; $display("FAIL thresh_trace %0d cycles differ, first %s", trace_err, first_bad);
    end
    trace_err = 0;
  endtask

  task automatic test_clk_sel_abort();
    int d0;
    restart();
    run_window('0, rand_mask(2));
    d0 = dut_dones;
    for (int i = 0; i < 10; i++) begin drive(1, (i % 2) == 0, 0); tick(); end
    clk_sel = ~clk_sel;
    drive(1, 1, 0); tick();
    repeat (SETTLE) begin drive(1, 1, 1); tick(); end
    n_cmp++;
    if (dut_dones - d0 !== 0) begin
      n_bad++; $display("FAIL abort_no_done got %0d pulses want 0", dut_dones - d0);
    end
    n_cmp++;
    if ({error_origin, error_leading, cnt_origin, cnt_leading} !==
        {1'b0, 1'b1, CNT_W'(0), CNT_W'(2)}) begin
      n_bad++; $display("FAIL abort_hold got eo=%b el=%b co=%0d cl=%0d want 0 1 0 2",
                        error_origin, error_leading, cnt_origin, cnt_leading);
    end
    run_window('0, '0);
    n_cmp++;
    if ({win_done, error_origin, error_leading, cnt_origin, cnt_leading} !==
        {1'b1, 1'b0, 1'b0, CNT_W'(0), CNT_W'(0)}) begin
      n_bad++; $display("FAIL abort_fresh got done=%b eo=%b el=%b co=%0d cl=%0d want 1 0 0 0 0",
                        win_done, error_origin, error_leading, cnt_origin, cnt_leading);
    end
    n_cmp++;
    if (trace_err !== 0) begin
      n_bad++; $display("FAIL abort_trace %0d cycles differ, first %s", trace_err, first_bad);
    end
    trace_err = 0;
  endtask

  task automatic test_valid_toggle();
    int d0, at = -1;
    logic [2*CNT_W-1:0] cnts = '1;
    restart();
    d0 = dut_dones;
    for (int i = 0; i < 2 * WIN + 2; i++) begin
      drive((i % 2) == 0, (i % 2) == 1, (i % 2) == 1); tick();
      if (win_done === 1'b1 && at < 0) begin at = i; cnts = {cnt_origin, cnt_leading}; end
    end
    n_cmp++;
    if (dut_dones - d0 !== 1 || at !== 2 * WIN - 1) begin
      n_bad++; $display("FAIL toggle_done got %0d pulses at %0d want 1 at %0d",
                        dut_dones - d0, at, 2 * WIN - 1);
    end
    n_cmp++;
    if (cnts !== '0) begin
      n_bad++; $display("FAIL toggle_counts got %h want 0", cnts);
    end
    n_cmp++;
    if (trace_err !== 0) begin
      n_bad++; $display("FAIL toggle_trace %0d cycles differ, first %s", trace_err, first_bad);
    end
    trace_err = 0;
  endtask

  task automatic test_rst_en_drop();
    restart();
    run_window(rand_mask(4), '0);
    repeat (8) begin drive(1, 1, 1); tick(); end
    rst = 1'b1; drive(1, 1, 1); tick();
    n_cmp++;
    if (act_vec() !== '0) begin
      n_bad++; $display("FAIL rst_mid got %h want 0", act_vec());
    end
    rst = 1'b0;
    restart();
    run_window('0, rand_mask(3));
    n_cmp++;
    if (error_leading !== 1'b1) begin
      n_bad++; $display("FAIL endrop_setup got el=%b want 1", error_leading);
    end
    repeat (5) begin drive(1, 0, 1); tick(); end
    en = 1'b0; drive(1, 0, 1); tick();
    n_cmp++;
    if (act_vec() !== '0) begin
      n_bad++; $display("FAIL endrop got %h want 0", act_vec());
    end
    n_cmp++;
    if (trace_err !== 0) begin
      n_bad++; $display("FAIL rst_en_trace %0d cycles differ, first %s", trace_err, first_bad);
    end
    trace_err = 0;
    en = 1'b1;
  endtask

  task automatic test_random();
    int d0 = dut_dones, m0 = m_dones;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      en  = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 49) == 0) clk_sel = ~clk_sel;
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      tick();
    end
    rst = 1'b0;
    n_cmp++;
    if (dut_dones - d0 !== m_dones - m0) begin
      n_bad++; $display("FAIL random_windows got %0d want %0d", dut_dones - d0, m_dones - m0);
    end
    n_cmp++;
    if (trace_err !== 0) begin
      n_bad++; $display("FAIL random_trace %0d cycles differ, first %s", trace_err, first_bad);
    end
    trace_err = 0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; clk_sel = 1'b0;
    d_o = '0; d_l = '0; d_s = '0;
    test_reset();
    test_clean();
    test_origin_errs();
    test_threshold();
    test_clk_sel_abort();
    test_valid_toggle();
    test_rst_en_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
